// File: rtl/afifo_rd_drain_ctrl.sv
// Read-side drain controller for the async FIFO: pops rdata into a 2-entry
// skid buffer, handles empty back-pressure with a bounded wait, and supports underflow injection.
module afifo_rd_drain_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MAX_EMPTY_WAIT = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  inj_underflow,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  timeout,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wait_count
);

  localparam int unsigned EW = $clog2(MAX_EMPTY_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STALL   = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [EW-1:0]         empty_cnt_q, empty_cnt_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0]  wait_count_q, wait_count_d;
  logic                  uf_err_q, uf_err_d;

  logic active, pop_norm, inj_pop, out_fire;

  // Pop decisions: a normal pop needs room in the skid buffer; an injected pop only fires on empty.
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_STALL);
    pop_norm = active && !rempty && (occ_q < 2'd2);
    inj_pop  = inj_underflow && rempty && (state_q != S_TIMEOUT);
    out_fire = (occ_q != 2'd0) && m_ready;
  end

  always_comb begin
    state_d      = state_q;
    empty_cnt_d  = empty_cnt_q;
    wait_count_d = wait_count_q;
    rd_count_d   = rd_count_q;
    uf_err_d     = uf_err_q | inj_pop;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    unique case (state_q)
      S_IDLE: if (en) state_d = S_RUN;
      S_RUN: begin
        if (!en)        state_d = S_IDLE;
        else if (rempty) state_d = S_STALL;
      end
      S_STALL: begin
        if (!en) begin
          state_d     = S_IDLE;
          empty_cnt_d = '0;
        end else if (!rempty) begin
          state_d     = S_RUN;
          empty_cnt_d = '0;
        end else if (empty_cnt_q == EW'(MAX_EMPTY_WAIT - 1)) begin
          state_d     = S_TIMEOUT;
          empty_cnt_d = '0;
        end else begin
          empty_cnt_d = empty_cnt_q + EW'(1);
        end
      end
      S_TIMEOUT: if (!en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_STALL) && rempty && (wait_count_q != {CNT_WIDTH{1'b1}}))
      wait_count_d = wait_count_q + CNT_WIDTH'(1);

    if (pop_norm && (rd_count_q != {CNT_WIDTH{1'b1}}))
      rd_count_d = rd_count_q + CNT_WIDTH'(1);

    // Skid buffer: buf0 is the head; push+pop only coexist at occ==1.
    unique case ({pop_norm, out_fire})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = rdata;
        else               buf1_d = rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: buf0_d = rdata;
      default: ;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_IDLE;
      occ_q        <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      empty_cnt_q  <= '0;
      rd_count_q   <= '0;
      wait_count_q <= '0;
      uf_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      empty_cnt_q  <= empty_cnt_d;
      rd_count_q   <= rd_count_d;
      wait_count_q <= wait_count_d;
      uf_err_q     <= uf_err_d;
    end
  end

  assign rinc          = rrst_n && (pop_norm || inj_pop);
  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf0_q;
  assign timeout       = (state_q == S_TIMEOUT);
  assign underflow_err = uf_err_q;
  assign rd_count      = rd_count_q;
  assign wait_count    = wait_count_q;

endmodule

// File: tb/tb_afifo_rd_drain_ctrl.sv
// Bench for afifo_rd_drain_ctrl: behavioural FIFO model on the read port, scoreboard
// queue on the downstream side, a per-cycle vector table for back-pressure, and hand sequences.
module tb_afifo_rd_drain_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned MW = 16;
  localparam int unsigned CW = 32;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          en = 1'b0;
  logic          inj_underflow = 1'b0;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          timeout;
  logic          underflow_err;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wait_count;

  always #5 rclk = ~rclk;

  afifo_rd_drain_ctrl #(
    .DATA_WIDTH    (DW),
    .MAX_EMPTY_WAIT(MW),
    .CNT_WIDTH     (CW)
  ) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .en           (en),
    .inj_underflow(inj_underflow),
    .rempty       (rempty),
    .rdata        (rdata),
    .rinc         (rinc),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .timeout      (timeout),
    .underflow_err(underflow_err),
    .rd_count     (rd_count),
    .wait_count   (wait_count)
  );

  // Behavioural FIFO read port
  logic [DW-1:0] mem [0:63];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr[5:0]];

  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int rinc_cnt = 0;
  bit pop_pend = 1'b0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          x_rinc;
    logic          x_valid;
    logic [DW-1:0] x_data;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fifo_put(input logic [DW-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  // Mid-cycle sample: count pops, check every downstream handshake against the scoreboard.
  task automatic sample();
    logic [DW-1:0] e;
    @(negedge rclk);
    if (rinc) rinc_cnt++;
    pop_pend = rinc && !rempty;
    if (m_valid && m_ready) begin
      chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(m_data), 32'(e));
      end
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
    if (pop_pend) rd_ptr++;
    pop_pend = 1'b0;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
    pop_pend = 1'b0;
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    en = 1'b0;
    inj_underflow = 1'b0;
    m_ready = 1'b0;
    #3;
    flush();
    sample();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_uf_err", 32'(underflow_err), 32'd0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wait_count", wait_count, 32'd0);
    step();
    rrst_n = 1'b1;
    rinc_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, first, last, early;

    // Stream of 8 words at full rate
    apply_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_put(DW'(i));
    en = 1'b1;
    vcnt = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (m_valid) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
      step();
    end
    chk("stream_rinc_cnt", 32'(rinc_cnt), 32'd8);
    chk("stream_valid_cnt", 32'(vcnt), 32'd8);
    chk("stream_contiguous", 32'(last - first + 1), 32'd8);
    chk("stream_rd_count", rd_count, 32'd8);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure vectors: 4 words queued, m_ready low for 6 cycles
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA2};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    apply_reset();
    for (int i = 0; i < 4; i++) fifo_put(8'hA0 + DW'(i));
    for (int i = 0; i < 11; i++) begin
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      sample();
      chk($sformatf("bp_rinc[%0d]", i), 32'(rinc), 32'(tbl[i].x_rinc));
      chk($sformatf("bp_valid[%0d]", i), 32'(m_valid), 32'(tbl[i].x_valid));
      if (tbl[i].x_valid) chk($sformatf("bp_data[%0d]", i), 32'(m_data), 32'(tbl[i].x_data));
      step();
    end
    chk("bp_rinc_cnt", 32'(rinc_cnt), 32'd4);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Timeout on a permanently empty FIFO
    apply_reset();
    m_ready = 1'b1;
    en = 1'b1;
    early = 0;
    for (int i = 0; i < 18; i++) begin
      sample();
      if (timeout) early++;
      if (i == 17) chk("to_wait_before", wait_count, 32'd15);
      step();
    end
    chk("to_not_early", 32'(early), 32'd0);
    sample();
    chk("to_timeout_set", 32'(timeout), 32'd1);
    chk("to_wait_count", wait_count, 32'd16);
    step();
    inj_underflow = 1'b1;
    sample();
    chk("to_inj_no_rinc", 32'(rinc), 32'd0);
    step();
    inj_underflow = 1'b0;
    sample();
    chk("to_inj_no_err", 32'(underflow_err), 32'd0);
    step();
    fifo_put(8'h77);
    fifo_put(8'h78);
    rinc_cnt = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("to_rinc_held", 32'(rinc_cnt), 32'd0);
    chk("to_timeout_held", 32'(timeout), 32'd1);
    chk("to_no_valid", 32'(m_valid), 32'd0);
    chk("to_wait_frozen", wait_count, 32'd16);
    en = 1'b0;
    cyc();
    sample();
    chk("to_cleared", 32'(timeout), 32'd0);
    chk("to_idle_no_rinc", 32'(rinc), 32'd0);
    step();

    // Underflow injection: ignored while data present, sticky error on empty
    apply_reset();
    m_ready = 1'b1;
    fifo_put(8'h55);
    inj_underflow = 1'b1;
    sample();
    chk("uf_ignored_rinc", 32'(rinc), 32'd0);
    step();
    inj_underflow = 1'b0;
    sample();
    chk("uf_ignored_err", 32'(underflow_err), 32'd0);
    step();
    en = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("uf_pre_rd_count", rd_count, 32'd1);
    chk("uf_pre_sb_empty", 32'(exp_q.size()), 32'd0);
    rinc_cnt = 0;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      inj_underflow = (i == 0);
      sample();
      if (i == 0) chk("uf_rinc_pulse", 32'(rinc), 32'd1);
      if (m_valid) vcnt++;
      step();
    end
    inj_underflow = 1'b0;
    chk("uf_rinc_once", 32'(rinc_cnt), 32'd1);
    chk("uf_err_sticky", 32'(underflow_err), 32'd1);
    chk("uf_no_valid", 32'(vcnt), 32'd0);
    chk("uf_rd_count", rd_count, 32'd1);
    en = 1'b0;
    cyc();

    // Asynchronous reset with the skid buffer full
    apply_reset();
    for (int i = 0; i < 4; i++) fifo_put(8'h11 + DW'(i));
    en = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("mr_pre_valid", 32'(m_valid), 32'd1);
    chk("mr_pre_rd_count", rd_count, 32'd2);
    #2;
    rrst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_rinc", 32'(rinc), 32'd0);
    chk("mr_rd_count", rd_count, 32'd0);
    chk("mr_m_data", 32'(m_data), 32'd0);
    en = 1'b0;
    flush();
    cyc();
    rrst_n = 1'b1;
    fifo_put(8'h21);
    fifo_put(8'h22);
    m_ready = 1'b1;
    sample();
    chk("mr_idle_rinc", 32'(rinc), 32'd0);
    step();
    en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("mr_post_rd_count", rd_count, 32'd2);
    chk("mr_post_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
